// File: rtl/nbit_shift_multiplier_bcd_seq_if.sv
// Operand/result bundle for the sequential shift-add multiplier with BCD conversion.
// The master drives operands and start; the slave returns status and results.
interface nbit_shift_multiplier_bcd_seq_if #(
  parameter int unsigned N = 8
);
  localparam int unsigned DIGITS = ((2 * N) / 3) + 1;

  logic                  start;
  logic                  signed_mode;
  logic [N-1:0]          a_in;
  logic [N-1:0]          b_in;
  logic                  busy;
  logic                  finish;
  logic [2*N-1:0]        out;
  logic [4*DIGITS-1:0]   bcd;
  logic                  neg;

  modport master (
    output start, signed_mode, a_in, b_in,
    input  busy, finish, out, bcd, neg
  );

  modport slave (
    input  start, signed_mode, a_in, b_in,
    output busy, finish, out, bcd, neg
  );
endinterface

// File: rtl/nbit_shift_multiplier_bcd_seq.sv
// Sequential N-bit shift-add multiplier (signed/unsigned) followed by a serial
// double-dabble stage producing the BCD magnitude of the product.
module nbit_shift_multiplier_bcd_seq #(
  parameter int unsigned N = 8
) (
  input logic                          clk,
  input logic                          reset,
  nbit_shift_multiplier_bcd_seq_if.slave bus
);
  localparam int unsigned DIGITS = ((2 * N) / 3) + 1;
  localparam int unsigned W      = 2 * N;
  localparam int unsigned BW     = 4 * DIGITS;
  localparam int unsigned CW     = $clog2(W);

  localparam logic [CW-1:0] MulLast = CW'(N - 1);
  localparam logic [CW-1:0] BcdLast = CW'(W - 1);

  typedef enum logic [1:0] {StIdle, StMul, StBcd, StDone} state_e;

  state_e          state_q;
  logic [W-1:0]    mcand_q;
  logic [N-1:0]    mplier_q;
  logic [W-1:0]    acc_q;
  logic            sign_q;
  logic [CW-1:0]   cnt_q;
  logic [W-1:0]    bin_q;
  logic [BW-1:0]   work_q;

  logic [W-1:0]    out_q;
  logic [BW-1:0]   bcd_q;
  logic            neg_q;
  logic            finish_q;
  logic            busy_q;

  logic [N-1:0]    mag_a;
  logic [N-1:0]    mag_b;
  logic [W-1:0]    acc_sum;
  logic [BW-1:0]   work_adj;
  logic [BW-1:0]   work_shift;

  // |-2^(N-1)| wraps to 2^(N-1), which is still correct read as unsigned.
  always_comb begin
    mag_a = bus.a_in;
    mag_b = bus.b_in;
    if (bus.signed_mode && bus.a_in[N-1]) mag_a = -bus.a_in;
    if (bus.signed_mode && bus.b_in[N-1]) mag_b = -bus.b_in;
  end

  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : {W{1'b0}});

  always_comb begin
    work_adj = work_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (work_q[4*i +: 4] >= 4'd5) work_adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
    end
  end

  assign work_shift = {work_adj[BW-2:0], bin_q[W-1]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      sign_q   <= 1'b0;
      cnt_q    <= '0;
      bin_q    <= '0;
      work_q   <= '0;
      out_q    <= '0;
      bcd_q    <= '0;
      neg_q    <= 1'b0;
      finish_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      finish_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            mcand_q  <= {{N{1'b0}}, mag_a};
            mplier_q <= mag_b;
            acc_q    <= '0;
            sign_q   <= bus.signed_mode & (bus.a_in[N-1] ^ bus.b_in[N-1]);
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= StMul;
          end
        end
        StMul: begin
          acc_q    <= acc_sum;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          if (cnt_q == MulLast) begin
            // Hand the final product straight to the converter.
            cnt_q   <= '0;
            bin_q   <= acc_sum;
            work_q  <= '0;
            state_q <= StBcd;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        StBcd: begin
          work_q <= work_shift;
          bin_q  <= bin_q << 1;
          if (cnt_q == BcdLast) begin
            cnt_q    <= '0;
            out_q    <= sign_q ? -acc_q : acc_q;
            bcd_q    <= work_shift;
            neg_q    <= sign_q & (acc_q != '0);
            finish_q <= 1'b1;
            state_q  <= StDone;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.out    = out_q;
  assign bus.bcd    = bcd_q;
  assign bus.neg    = neg_q;
  assign bus.finish = finish_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_nbit_shift_multiplier_bcd_seq.sv
// Scoreboard bench for the shift-add multiplier with BCD output (N=5, DIGITS=4).
module tb_nbit_shift_multiplier_bcd_seq;
  localparam int unsigned N   = 5;
  localparam int          LAT = 3 * N + 1;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  nbit_shift_multiplier_bcd_seq_if #(.N(N)) bus ();

  nbit_shift_multiplier_bcd_seq #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [9:0]  out;
    logic [15:0] bcd;
    logic        neg;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: every finish strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset && bus.finish === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_finish: got finish at cycle %0d, expected none", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check($sformatf("op%0d_out", e.id), 32'(bus.out), 32'(e.out));
        check($sformatf("op%0d_bcd", e.id), 32'(bus.bcd), 32'(e.bcd));
        check($sformatf("op%0d_neg", e.id), 32'(bus.neg), 32'(e.neg));
        check($sformatf("op%0d_cycle", e.id), 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (bus.busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy=%b, expected 0 within 200 cycles", bus.busy);
    end
  endtask

  // Drive one capture, then scramble the operands to prove they are not re-read.
  task automatic issue(input int id, input logic [4:0] a, input logic [4:0] b, input logic sm,
                       input logic [9:0] eo, input logic [15:0] eb, input logic en);
    wait_idle();
    bus.a_in        = a;
    bus.b_in        = b;
    bus.signed_mode = sm;
    bus.start       = 1'b1;
    sb.push_back('{id: id, out: eo, bcd: eb, neg: en, cyc: cyc + LAT});
    @(negedge clk);
    bus.start       = 1'b0;
    bus.a_in        = ~a;
    bus.b_in        = b ^ 5'h15;
    bus.signed_mode = ~sm;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_out"},    32'(bus.out),    32'd0);
    check({tag, "_bcd"},    32'(bus.bcd),    32'd0);
    check({tag, "_neg"},    32'(bus.neg),    32'd0);
    check({tag, "_finish"}, 32'(bus.finish), 32'd0);
    check({tag, "_busy"},   32'(bus.busy),   32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion, expected finish within 100000 time units");
    $fatal(1);
  end

  initial begin
    int c0;
    bus.start       = 1'b0;
    bus.signed_mode = 1'b0;
    bus.a_in        = '0;
    bus.b_in        = '0;

    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    reset = 1'b1;
    @(negedge clk);

    issue(1, 5'd26, 5'd30, 1'b0, 10'd780, 16'h0780, 1'b0);
    issue(2, 5'd13, 5'd13, 1'b0, 10'd169, 16'h0169, 1'b0);
    issue(3, 5'd31, 5'd31, 1'b0, 10'd961, 16'h0961, 1'b0);
    issue(4, 5'b10011, 5'd13, 1'b1, 10'h357, 16'h0169, 1'b1);
    issue(5, 5'b10000, 5'b10000, 1'b1, 10'd256, 16'h0256, 1'b0);
    issue(6, 5'd0, 5'b11011, 1'b1, 10'd0, 16'h0000, 1'b0);
    issue(7, 5'b10000, 5'd5, 1'b1, 10'h3b0, 16'h0080, 1'b1);

    // A start pulse while busy must be dropped; results stay put meanwhile.
    issue(8, 5'd9, 5'd11, 1'b0, 10'd99, 16'h0099, 1'b0);
    repeat (3) @(negedge clk);
    check("hold_out", 32'(bus.out), 32'h3b0);
    check("hold_bcd", 32'(bus.bcd), 32'h0080);
    bus.a_in        = 5'd3;
    bus.b_in        = 5'd3;
    bus.signed_mode = 1'b0;
    bus.start       = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;

    // Held start: second capture lands on the first IDLE cycle after DONE.
    wait_idle();
    c0              = cyc;
    bus.a_in        = 5'd21;
    bus.b_in        = 5'd3;
    bus.signed_mode = 1'b0;
    bus.start       = 1'b1;
    sb.push_back('{id: 9, out: 10'd63, bcd: 16'h0063, neg: 1'b0, cyc: c0 + LAT});
    sb.push_back('{id: 10, out: 10'd493, bcd: 16'h0493, neg: 1'b0, cyc: c0 + LAT + 1 + LAT});
    @(negedge clk);
    bus.a_in = 5'd17;
    bus.b_in = 5'd29;
    repeat (16) @(negedge clk);
    @(negedge clk);
    bus.start = 1'b0;

    // Abort during the BCD phase.
    issue(11, 5'd27, 5'd19, 1'b0, 10'd513, 16'h0513, 1'b0);
    repeat (7) @(negedge clk);
    check("abort_busy_before", 32'(bus.busy), 32'd1);
    @(posedge clk);
    #2;
    reset = 1'b0;
    sb.delete();
    #1;
    check_zero("abort");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    issue(12, 5'd27, 5'd19, 1'b0, 10'd513, 16'h0513, 1'b0);

    for (int n = 0; n < 200 && sb.size() != 0; n++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("drain", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
